// File: rtl/uniman_pkg.sv
// Shared constants for the UniMan control/timebase endpoint.
// Contents: command opcodes, register addresses, FAST flit field offsets,
// register-select enum and a saturating-increment helper for the statistics counters.
package uniman_pkg;

  localparam logic [7:0] OP_RD      = 8'h01;
  localparam logic [7:0] OP_WR      = 8'h02;
  localparam logic [7:0] OP_RSP_BIT = 8'h80;
  localparam logic [7:0] OP_ERR     = 8'hFF;

  localparam logic [15:0] ADDR_INTERVAL  = 16'h0000;
  localparam logic [15:0] ADDR_TIMESTAMP = 16'h0001;
  localparam logic [15:0] ADDR_CTRL      = 16'h0002;
  localparam logic [15:0] ADDR_FWD_CNT   = 16'h0003;
  localparam logic [15:0] ADDR_DROP_CNT  = 16'h0004;

  localparam logic [1:0] HDR_CMD = 2'b11;

  localparam int unsigned HDR_HI  = 133;
  localparam int unsigned HDR_LO  = 132;
  localparam int unsigned DST_HI  = 127;
  localparam int unsigned DST_LO  = 120;
  localparam int unsigned OP_HI   = 119;
  localparam int unsigned OP_LO   = 112;
  localparam int unsigned ADDR_HI = 111;
  localparam int unsigned ADDR_LO = 96;
  localparam int unsigned DATA_HI = 63;
  localparam int unsigned DATA_LO = 0;

  typedef enum logic [2:0] {
    RegInterval,
    RegTimestamp,
    RegCtrl,
    RegFwdCnt,
    RegDropCnt,
    RegNone
  } reg_sel_e;

  function automatic logic [31:0] sat_inc32(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/uniman_ctrl_timebase_if.sv
// Control-channel bundle for uniman_ctrl_timebase.
// cin_*  : incoming FAST flits (cin_data_wr/cin_data from upstream, cin_ready back).
// cout_* : outgoing flits (cout_data_wr/cout_data to downstream, cout_ready back).
// master = the environment side, slave = the endpoint block.
interface uniman_ctrl_timebase_if #(
  parameter int unsigned W_PKT = 134
) ();
  logic             cin_data_wr;
  logic [W_PKT-1:0] cin_data;
  logic             cin_ready;
  logic             cout_data_wr;
  logic [W_PKT-1:0] cout_data;
  logic             cout_ready;

  modport master (
    output cin_data_wr, cin_data, cout_ready,
    input  cin_ready, cout_data_wr, cout_data
  );

  modport slave (
    input  cin_data_wr, cin_data, cout_ready,
    output cin_ready, cout_data_wr, cout_data
  );
endinterface

// File: rtl/uniman_flit_fifo.sv
// Synchronous W x DEPTH flit FIFO with occupancy count.
// Ports: clk, reset (async, active-low), push/wdata (write), pop (read strobe),
// rdata (current head, valid when count != 0), count (occupancy).
// A push while full is ignored unless a pop happens in the same cycle.
module uniman_flit_fifo #(
  parameter int unsigned W     = 134,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the count qualifies the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = cnt_q;
endmodule

// File: rtl/uniman_ctrl_timebase.sv
// Timebase and control-channel endpoint for the UniMan gateway.
// Ports: clk, reset (async, active-low), bus (uniman_ctrl_timebase_if.slave: cin/cout flit
// channels), cur_timestamp (free-running timestamp), tick (1-cycle pulse on each increment).
// Commands (hdr 11, dst == LMID) are executed and answered; all other flits are forwarded.
// Every output flit goes through uniman_flit_fifo.
// Optional macro UNIMAN_CTRL_STATS_EN adds FWD_CNT (0x3) and DROP_CNT (0x4) counters.
module uniman_ctrl_timebase
  import uniman_pkg::*;
#(
  parameter int unsigned LMID         = 8,
  parameter int unsigned W_PKT        = 134,
  parameter int unsigned W_TS         = 16,
  parameter int unsigned W_INTV       = 32,
  parameter int unsigned INTV_DEFAULT = 125000000,
  parameter int unsigned TS_INC       = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uniman_ctrl_timebase_if.slave bus,
  output logic [W_TS-1:0]       cur_timestamp,
  output logic                  tick
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [W_INTV-1:0] interval_q, interval_d, timer_q, timer_d;
  logic [W_TS-1:0]   ts_q, ts_d;
  logic              run_q, run_d;
  logic              cin_ready_q, cout_wr_q;
  logic [W_PKT-1:0]  cout_data_q, push_data, head;
  logic [CW-1:0]     count, count_nxt;
  logic              accept, is_cmd, op_ok, do_write, pop, tick_c;
  logic [7:0]        f_op;
  logic [15:0]       f_addr;
  logic [63:0]       f_data, rd_val, wr_val, rsp_val;
  reg_sel_e          sel;

  assign accept = bus.cin_data_wr && cin_ready_q;
  assign f_op   = bus.cin_data[OP_HI:OP_LO];
  assign f_addr = bus.cin_data[ADDR_HI:ADDR_LO];
  assign f_data = bus.cin_data[DATA_HI:DATA_LO];
  assign is_cmd = (bus.cin_data[HDR_HI:HDR_LO] == HDR_CMD)
               && (bus.cin_data[DST_HI:DST_LO] == 8'(LMID));

  always_comb begin
    case (f_addr)
      ADDR_INTERVAL:  sel = RegInterval;
      ADDR_TIMESTAMP: sel = RegTimestamp;
      ADDR_CTRL:      sel = RegCtrl;
`ifdef UNIMAN_CTRL_STATS_EN
      ADDR_FWD_CNT:   sel = RegFwdCnt;
      ADDR_DROP_CNT:  sel = RegDropCnt;
`endif
      default:        sel = RegNone;
    endcase
  end

  assign op_ok    = ((f_op == OP_RD) || (f_op == OP_WR)) && (sel != RegNone);
  assign do_write = accept && is_cmd && op_ok && (f_op == OP_WR);

`ifdef UNIMAN_CTRL_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (accept && !is_cmd) fwd_cnt_d = sat_inc32(fwd_cnt_q);
    if (bus.cin_data_wr && !cin_ready_q) drop_cnt_d = sat_inc32(drop_cnt_q);
    // Clears cannot collide with increments: a write needs an accept, a drop excludes one.
    if (do_write && (sel == RegFwdCnt)) fwd_cnt_d = '0;
    if (do_write && (sel == RegDropCnt)) drop_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  // wr_val is the register contents after a write (truncated to register width).
  always_comb begin
    rd_val = '0;
    wr_val = '0;
    case (sel)
      RegInterval: begin
        rd_val = 64'(interval_q);
        wr_val = 64'(f_data[W_INTV-1:0]);
      end
      RegTimestamp: begin
        rd_val = 64'(ts_q);
        wr_val = 64'(f_data[W_TS-1:0]);
      end
      RegCtrl: begin
        rd_val = 64'(run_q);
        wr_val = 64'(f_data[0]);
      end
`ifdef UNIMAN_CTRL_STATS_EN
      RegFwdCnt:  rd_val = 64'(fwd_cnt_q);
      RegDropCnt: rd_val = 64'(drop_cnt_q);
`endif
      default: ;
    endcase
  end

  assign rsp_val = (f_op == OP_WR) ? wr_val : rd_val;

  always_comb begin
    push_data = bus.cin_data;
    if (is_cmd) begin
      push_data[OP_HI:OP_LO]     = op_ok ? (f_op | OP_RSP_BIT) : OP_ERR;
      push_data[DATA_HI:DATA_LO] = op_ok ? rsp_val : 64'd0;
    end
  end

  // Timer and register next state; a register write overrides the timer update.
  always_comb begin
    tick_c     = run_q && (timer_q == interval_q);
    timer_d    = timer_q;
    ts_d       = ts_q;
    interval_d = interval_q;
    run_d      = run_q;
    if (run_q) begin
      if (tick_c) begin
        timer_d = '0;
        ts_d    = ts_q + W_TS'(TS_INC);
      end else begin
        timer_d = timer_q + W_INTV'(1);
      end
    end
    if (do_write) begin
      case (sel)
        RegInterval: begin
          interval_d = f_data[W_INTV-1:0];
          timer_d    = '0;
        end
        RegTimestamp: ts_d  = f_data[W_TS-1:0];
        RegCtrl:      run_d = f_data[0];
        default: ;
      endcase
    end
  end

  uniman_flit_fifo #(
    .W     (W_PKT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign pop       = (count != '0) && bus.cout_ready;
  assign count_nxt = count + CW'(accept) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      interval_q  <= W_INTV'(INTV_DEFAULT);
      timer_q     <= '0;
      ts_q        <= '0;
      run_q       <= 1'b1;
      cin_ready_q <= 1'b1;
      cout_wr_q   <= 1'b0;
      cout_data_q <= '0;
    end else begin
      interval_q  <= interval_d;
      timer_q     <= timer_d;
      ts_q        <= ts_d;
      run_q       <= run_d;
      // Next-cycle occupancy leaves room for a flit accepted while this flag is still high.
      cin_ready_q <= (32'(count_nxt) <= FIFO_DEPTH - 2);
      cout_wr_q   <= pop;
      if (pop) cout_data_q <= head;
    end
  end

  assign bus.cin_ready    = cin_ready_q;
  assign bus.cout_data_wr = cout_wr_q;
  assign bus.cout_data    = cout_data_q;
  assign cur_timestamp    = ts_q;
  assign tick             = tick_c;
endmodule

// File: tb/tb_uniman_ctrl_timebase.sv
module tb_uniman_ctrl_timebase;
  localparam int unsigned WP = 134;
  typedef logic [WP-1:0] flit_t;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  exp_op;
    logic [63:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] cur_timestamp;
  logic tick;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  flit_t rsp_q[$];
  int rsp_cyc[$];

  uniman_ctrl_timebase_if #(.W_PKT(WP)) bus_if ();

  uniman_ctrl_timebase #(
    .LMID         (8),
    .W_PKT        (WP),
    .W_TS         (16),
    .W_INTV       (32),
    .INTV_DEFAULT (9),
    .TS_INC       (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_if),
    .cur_timestamp (cur_timestamp),
    .tick          (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.cout_data_wr) begin
      rsp_q.push_back(bus_if.cout_data);
      rsp_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  function automatic flit_t mk(logic [1:0] hdr, logic [7:0] dst, logic [7:0] op,
                               logic [15:0] addr, logic [63:0] data);
    flit_t f;
    f = '0;
    f[133:132] = hdr;
    f[131:128] = 4'hA;
    f[127:120] = dst;
    f[119:112] = op;
    f[111:96]  = addr;
    f[95:64]   = {16'hC0DE, addr};
    f[63:0]    = data;
    return f;
  endfunction

  task automatic check(string name, flit_t act, flit_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(flit_t f, output int c);
    @(posedge clk);
    #1;
    c = cyc;
    bus_if.cin_data_wr = 1'b1;
    bus_if.cin_data    = f;
    @(posedge clk);
    #1;
    bus_if.cin_data_wr = 1'b0;
  endtask

  task automatic get_rsp(output flit_t f, output int c, output bit ok);
    ok = 1'b0;
    f  = '0;
    c  = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_q.size() != 0) begin
        f  = rsp_q.pop_front();
        c  = rsp_cyc.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_chk++;
    n_fail++;
    $display("FAIL rsp_timeout: got no cout flit, expected one within 20 cycles");
  endtask

  task automatic wait_tick(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tick) begin
        c = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL tick_timeout: got no tick, expected one within 200 cycles");
  endtask

  task automatic do_cmd(string name, logic [7:0] op, logic [15:0] addr, logic [63:0] data,
                        logic [7:0] eop, logic [63:0] edata);
    flit_t r;
    int c, rc;
    bit ok;
    send(mk(2'b11, 8'd8, op, addr, data), c);
    get_rsp(r, rc, ok);
    if (ok) begin
      check(name, r, mk(2'b11, 8'd8, eop, addr, edata));
      check({name, "_latency"}, flit_t'(rc - c), flit_t'(2));
    end
  endtask

  vec_t vecs[14];

  initial begin
    int x, t1, t2, c, rc, ts0;
    bit ok, changed;
    flit_t r;
    flit_t fw[4];

    vecs[0]  = '{8'h02, 16'h0002, 64'h0,           8'h82, 64'h0};
    vecs[1]  = '{8'h02, 16'h0001, 64'h5,           8'h82, 64'h5};
    vecs[2]  = '{8'h01, 16'h0001, 64'h0,           8'h81, 64'h5};
    vecs[3]  = '{8'h01, 16'h0000, 64'h0,           8'h81, 64'h9};
    vecs[4]  = '{8'h02, 16'h0000, 64'h1_2345_6789, 8'h82, 64'h2345_6789};
    vecs[5]  = '{8'h01, 16'h0000, 64'h0,           8'h81, 64'h2345_6789};
    vecs[6]  = '{8'h01, 16'h0002, 64'h0,           8'h81, 64'h0};
    vecs[7]  = '{8'h05, 16'h0000, 64'h1111,        8'hFF, 64'h0};
    vecs[8]  = '{8'h01, 16'h0007, 64'h0,           8'hFF, 64'h0};
    vecs[9]  = '{8'h02, 16'h0100, 64'h5,           8'hFF, 64'h0};
`ifdef UNIMAN_CTRL_STATS_EN
    vecs[10] = '{8'h01, 16'h0003, 64'h0,           8'h81, 64'h0};
`else
    vecs[10] = '{8'h01, 16'h0003, 64'h0,           8'hFF, 64'h0};
`endif
    vecs[11] = '{8'h02, 16'h0000, 64'h9,           8'h82, 64'h9};
    vecs[12] = '{8'h02, 16'h0001, 64'h1_0005,      8'h82, 64'h5};
    vecs[13] = '{8'h01, 16'h0001, 64'h0,           8'h81, 64'h5};

    bus_if.cin_data_wr = 1'b0;
    bus_if.cin_data    = '0;
    bus_if.cout_ready  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cin_ready", flit_t'(bus_if.cin_ready), flit_t'(1));
    check("rst_cout_wr", flit_t'(bus_if.cout_data_wr), flit_t'(0));
    check("rst_cout_data", bus_if.cout_data, flit_t'(0));
    check("rst_ts", flit_t'(cur_timestamp), flit_t'(0));
    check("rst_tick", flit_t'(tick), flit_t'(0));
    @(negedge clk);
    reset = 1'b1;
    x = cyc;

    // Tick every 10 clocks, timestamp 0 -> 1 -> 2
    wait_tick(t1);
    check("first_tick_cycle", flit_t'(t1 - x), flit_t'(9));
    check("ts_at_tick1", flit_t'(cur_timestamp), flit_t'(0));
    @(posedge clk);
    #1;
    check("ts_after_tick1", flit_t'(cur_timestamp), flit_t'(1));
    wait_tick(t2);
    check("tick_period", flit_t'(t2 - t1), flit_t'(10));
    @(posedge clk);
    #1;
    check("ts_after_tick2", flit_t'(cur_timestamp), flit_t'(2));

    // Register read/write vectors (timer stopped by the first entry)
    for (int i = 0; i < 14; i++) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data,
             vecs[i].exp_op, vecs[i].exp_data);
    end

    // Frozen timestamp while run=0, then resume
    ts0 = int'(cur_timestamp);
    changed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((int'(cur_timestamp) != ts0) || tick) changed = 1'b1;
    end
    check("freeze_50", flit_t'(changed), flit_t'(0));
    check("freeze_ts", flit_t'(cur_timestamp), flit_t'(5));
    do_cmd("run_on", 8'h02, 16'h0002, 64'h3, 8'h82, 64'h1);
    wait_tick(t1);
    check("resume_ts_at_tick", flit_t'(cur_timestamp), flit_t'(5));
    @(posedge clk);
    #1;
    check("resume_ts_after", flit_t'(cur_timestamp), flit_t'(6));

    // Interval 3 -> ticks every 4 clocks, first 4 clocks after the write
    send(mk(2'b11, 8'd8, 8'h02, 16'h0000, 64'h3), c);
    wait_tick(t1);
    check("intv3_first", flit_t'(t1 - c), flit_t'(4));
    wait_tick(t2);
    check("intv3_period", flit_t'(t2 - t1), flit_t'(4));
    get_rsp(r, rc, ok);
    if (ok) check("intv3_rsp", r, mk(2'b11, 8'd8, 8'h82, 16'h0000, 64'h3));

    // Timestamp write in a tick cycle wins over the increment
    repeat (4) @(posedge clk);
    #1;
    check("collide_tick", flit_t'(tick), flit_t'(1));
    bus_if.cin_data_wr = 1'b1;
    bus_if.cin_data    = mk(2'b11, 8'd8, 8'h02, 16'h0001, 64'h1234);
    @(posedge clk);
    #1;
    bus_if.cin_data_wr = 1'b0;
    check("collide_ts", flit_t'(cur_timestamp), flit_t'(16'h1234));
    get_rsp(r, rc, ok);
    if (ok) check("collide_rsp", r, mk(2'b11, 8'd8, 8'h82, 16'h0001, 64'h1234));

    // Wrap 0xFFFF -> 0x0000
    do_cmd("ts_ffff", 8'h02, 16'h0001, 64'hFFFF, 8'h82, 64'hFFFF);
    wait_tick(t1);
    check("wrap_before", flit_t'(cur_timestamp), flit_t'(16'hFFFF));
    @(posedge clk);
    #1;
    check("wrap_after", flit_t'(cur_timestamp), flit_t'(0));

    // Backpressure: three forwarded flits fill the FIFO window, the fourth is dropped
    fw[0] = mk(2'b11, 8'd9, 8'h01, 16'h0000, 64'hAAAA_0001);
    fw[1] = mk(2'b10, 8'd8, 8'h02, 16'h0000, 64'hAAAA_0002);
    fw[2] = mk(2'b00, 8'd9, 8'h33, 16'h0042, 64'hAAAA_0003);
    fw[3] = mk(2'b01, 8'd9, 8'h44, 16'h0043, 64'hAAAA_0004);
    bus_if.cout_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_ready%0d", i), flit_t'(bus_if.cin_ready), flit_t'((i < 3) ? 1 : 0));
      bus_if.cin_data_wr = 1'b1;
      bus_if.cin_data    = fw[i];
      @(posedge clk);
      #1;
    end
    bus_if.cin_data_wr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_held", flit_t'(rsp_q.size()), flit_t'(0));
    check("bp_ready_low", flit_t'(bus_if.cin_ready), flit_t'(0));
    bus_if.cout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_rsp(r, rc, ok);
      if (ok) check($sformatf("bp_drain%0d", i), r, fw[i]);
    end
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_4th", flit_t'(rsp_q.size()), flit_t'(0));
    check("bp_ready_back", flit_t'(bus_if.cin_ready), flit_t'(1));

`ifdef UNIMAN_CTRL_STATS_EN
    do_cmd("fwd_cnt", 8'h01, 16'h0003, 64'h0, 8'h81, 64'h3);
    do_cmd("drop_cnt", 8'h01, 16'h0004, 64'h0, 8'h81, 64'h1);
    do_cmd("drop_clr", 8'h02, 16'h0004, 64'h7, 8'h82, 64'h0);
    do_cmd("drop_cnt0", 8'h01, 16'h0004, 64'h0, 8'h81, 64'h0);
`else
    do_cmd("fwd_cnt_absent", 8'h01, 16'h0003, 64'h0, 8'hFF, 64'h0);
    do_cmd("drop_cnt_absent", 8'h01, 16'h0004, 64'h0, 8'hFF, 64'h0);
`endif

    // Reset with queued flits and a command on cin
    bus_if.cout_ready = 1'b0;
    send(fw[2], c);
    send(fw[3], c);
    @(posedge clk);
    #1;
    bus_if.cin_data_wr = 1'b1;
    bus_if.cin_data    = mk(2'b11, 8'd8, 8'h02, 16'h0000, 64'h5);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus_if.cin_data_wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_if.cout_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_flushed", flit_t'(rsp_q.size()), flit_t'(0));
    do_cmd("rst_interval", 8'h01, 16'h0000, 64'h0, 8'h81, 64'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
